// File: rtl/cs_result_buffer.sv
// Result buffer behind the CS complex-sum core: drops the Y values produced while the
// warm-up window fills, queues the valid results in a FIFO and tracks overflow/counts.
module cs_result_buffer #(
    parameter int WARMUP = 9,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_en,
    input  logic [9:0]       y_in,
    output logic [9:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic [CNT_W-1:0] res_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(WARMUP + 1);
    localparam logic [SW-1:0] WARM_MAX  = SW'(WARMUP);
    localparam logic [SW-1:0] WARM_PROD = SW'(WARMUP - 1);

    logic [SW-1:0] sample_cnt;
    logic          pend;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_next;
    logic [AW:0]   rd_next;
    logic [9:0]    mem [DEPTH];
    logic [9:0]    head_next;
    logic          pop;
    logic          push;
    logic          drop;

    assign out_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = out_valid && out_ready;
    assign push      = pend && (!full || pop);
    assign drop      = pend && full && !pop;

    // out_data is a register: it follows the head, loads a value pushed into an
    // empty (or emptying) FIFO directly, and holds when the FIFO drains.
    always_comb begin
        rd_next   = pop  ? rd_ptr + 1'b1 : rd_ptr;
        wr_next   = push ? wr_ptr + 1'b1 : wr_ptr;
        head_next = out_data;
        if (wr_next != rd_next) begin
            if (push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
                head_next = y_in;
            end else begin
                head_next = mem[rd_next[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr[AW-1:0]] <= y_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
            pend       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_data   <= '0;
            ovf        <= 1'b0;
            res_cnt    <= '0;
            drop_cnt   <= '0;
        end else if (clr) begin
            sample_cnt <= '0;
            pend       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_data   <= '0;
            ovf        <= 1'b0;
            res_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            if (in_en && (sample_cnt != WARM_MAX)) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
            // The WARMUP-th capture and all later ones yield a Y one cycle later.
            pend     <= in_en && (sample_cnt >= WARM_PROD);
            wr_ptr   <= wr_next;
            rd_ptr   <= rd_next;
            out_data <= head_next;
            if (push && (res_cnt != '1)) begin
                res_cnt <= res_cnt + 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/cs_result_buffer.md
Name: cs_result_buffer

Overview:
- Sits directly downstream of the CS (complex-sum) core and consumes its 10-bit Y output.
- Tracks the CS 9-sample warm-up window and discards the invalid Y values produced while the window fills.
- Buffers the valid results in a FIFO and presents them on a valid/ready interface to the output sink.
- Reports overflow and result-count status.

Parameters:
- WARMUP, 9, number of accepted samples before the first valid CS result.
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- CNT_W, 16, width of the result and drop counters.

Ports:
- clk  in  1  single system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear; same effect as reset on the next posedge.
- in_en  in  1  high in a cycle where CS captures a new X sample at this posedge.
- y_in  in  10  CS output Y; registered in CS, so it is valid one posedge after the capturing in_en.
- out_data  out  10  FIFO head data.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts; a pop occurs when out_valid && out_ready at posedge.
- ovf  out  1  sticky: set when a valid result was dropped because the FIFO was full.
- res_cnt  out  CNT_W  valid results pushed into the FIFO; saturates at all-ones.
- drop_cnt  out  CNT_W  results dropped on overflow; saturates at all-ones.
- full  out  1  FIFO holds DEPTH entries.

Behaviour:
- Reset (async) or clr (sync) sets:
  - FIFO empty, out_valid=0, out_data=0, full=0;
  - ovf=0, res_cnt=0, drop_cnt=0;
  - sample counter=0, pend=0.
- Sample counter:
  - Increments on each in_en and saturates at WARMUP.
  - A captured sample is "producing" if the counter value before the increment is >= WARMUP-1, i.e. the WARMUP-th sample and every sample after it.
- pend flag:
  - Set to 1 at the posedge where a producing in_en is captured; otherwise cleared to 0.
  - At the next posedge, if pend=1, y_in is a valid result. Latency is fixed at 1 cycle after capture.
- Push:
  - Occurs at a posedge with pend=1.
  - Accepted if the FIFO is not full, or if a pop occurs in the same cycle (full with simultaneous pop: push accepted, occupancy unchanged).
  - Otherwise the result is dropped: ovf<=1, drop_cnt increments, FIFO contents are unchanged.
- Pop:
  - Occurs at a posedge with out_valid && out_ready.
  - The head advances; out_data shows the new head, or holds its last value when the FIFO empties.
- No bypass path: a push into an empty FIFO asserts out_valid at the following cycle, i.e. 2 cycles after capture.
- Simultaneous push and pop on a non-empty FIFO: occupancy unchanged, order preserved.
- Pointers are log2(DEPTH) bits plus one wrap bit; wrap-around is seamless.
- full = (occupancy == DEPTH); out_valid = (occupancy != 0).
- res_cnt increments on each accepted push; it and drop_cnt hold at the maximum value, with no wrap.
- ovf clears only on reset or clr.
- clr has priority over a push or pop in the same cycle; that push or pop is discarded.
- Reset asserted mid-stream discards all contents immediately; warm-up restarts from 0 after reset releases.
- in_en low cycles: counter holds and pend clears. Gaps in the stream are allowed; results still pair 1:1 with producing samples.
- y_in is ignored when pend=0.

Test Plan:
- Warm-up: reset, then in_en=1 for 12 cycles with out_ready=1. y_in values at posedges 1..12 after capture are 0x100+n; CS core tied so Y equals a ramp. Exactly 4 pushes occur, with values 0x109, 0x10A, 0x10B, 0x10C. res_cnt=4. out_valid first rises 2 cycles after the 9th capture.
- Backpressure/full: out_ready=0, 20 producing samples after warm-up. The FIFO holds the first 8 values in order and full=1. 12 drops occur: drop_cnt=12, ovf=1, res_cnt=8.
- Full with simultaneous pop: with full=1, assert out_ready=1 during continuous pushes. Every result is accepted, occupancy stays 8, drop_cnt does not change, and output order is intact.
- Gapped input: after warm-up, in_en pattern 1,0,0,1,0,1. Exactly 3 pushes occur, each sampling y_in one cycle after its capture.
- Reset mid-stream: assert reset asynchronously between clock edges with 5 entries queued. out_valid=0, ovf=0 and counters=0 immediately. The next 8 samples after release produce no pushes; the 9th does.
- clr and wrap: run 1000 results through a DEPTH=8 FIFO with random out_ready and compare against a scoreboard. Then pulse clr in the same cycle as a push and a pop: the FIFO is empty next cycle and res_cnt=0.
